// File: rtl/comp4_bist_ctrl_pkg.sv
// Shared definitions for the comp4 BIST controller: FSM state encoding and
// the bit positions of the {gt,eq,lt} flag triple.
package comp4_bist_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FLAG_W  = 3;
    localparam int FLAG_GT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 0;

endpackage

// File: rtl/comp4_bist_ctrl_comp_golden.sv
// Golden reference comparator: expected {gt,eq,lt} for unsigned operands a and b.
module comp_golden
    import comp4_bist_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [FLAG_W-1:0] flags_o
);

    always_comb begin
        flags_o          = '0;
        flags_o[FLAG_GT] = (a_i > b_i);
        flags_o[FLAG_EQ] = (a_i == b_i);
        flags_o[FLAG_LT] = (a_i < b_i);
    end

endmodule

// File: rtl/comp4_bist_ctrl.sv
// BIST controller for a comp4 magnitude comparator: sweeps all {a,b} pairs,
// checks the comparator flags against a golden model and records the results.
module comp4_bist_ctrl
    import comp4_bist_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    input  logic               gt_i,
    input  logic               eq_i,
    input  logic               lt_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [2*WIDTH-1:0] first_err,
    output logic [2:0]         first_flags
);

    localparam int VW    = 2 * WIDTH;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [VW-1:0]      vec_q, vec_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VW-1:0]      first_err_q, first_err_d;
    logic [FLAG_W-1:0]  first_flags_q, first_flags_d;

    logic [FLAG_W-1:0]  exp_flags;
    logic [FLAG_W-1:0]  obs_flags;
    logic               mismatch;
    logic               last_vec;
    logic [ERR_W-1:0]   err_inc;

    comp_golden #(.WIDTH(WIDTH)) u_golden (
        .a_i     (vec_q[VW-1:WIDTH]),
        .b_i     (vec_q[WIDTH-1:0]),
        .flags_o (exp_flags)
    );

    always_comb begin
        obs_flags          = '0;
        obs_flags[FLAG_GT] = gt_i;
        obs_flags[FLAG_EQ] = eq_i;
        obs_flags[FLAG_LT] = lt_i;
    end

    // A full-triple compare also flags non-one-hot comparator outputs.
    assign mismatch = (obs_flags != exp_flags);
    assign last_vec = &vec_q;
    assign err_inc  = (&err_q) ? err_q : err_q + ERR_W'(1);

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        settle_d      = settle_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        err_d         = err_q;
        first_err_d   = first_err_q;
        first_flags_d = first_flags_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_SETTLE;
                    vec_d         = '0;
                    settle_d      = SETTLE_INIT;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    err_d         = '0;
                    first_err_d   = '0;
                    first_flags_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_inc;
                    if (err_q == '0) begin
                        first_err_d   = vec_q;
                        first_flags_d = obs_flags;
                    end
                end
                if (last_vec) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !mismatch && (err_q == '0);
                end else begin
                    state_d  = ST_SETTLE;
                    vec_d    = vec_q + VW'(1);
                    settle_d = SETTLE_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            first_err_q   <= '0;
            first_flags_q <= '0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            settle_q      <= settle_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_q         <= err_d;
            first_err_q   <= first_err_d;
            first_flags_q <= first_flags_d;
        end
    end

    assign a_o         = vec_q[VW-1:WIDTH];
    assign b_o         = vec_q[WIDTH-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;
    assign first_err   = first_err_q;
    assign first_flags = first_flags_q;

endmodule
